// File: rtl/sar_pkg.sv
// sar_pkg
// Shared definitions for the SAR ADC control blocks: the default result
// width used by both the SAR controller and its oversampling scheduler, and
// the scheduler state encoding.
package sar_pkg;

  localparam int SAR_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    START = 2'd2,
    CONV  = 2'd3
  } sar_os_state_t;

endpackage

// File: rtl/sar_tick_counter.sv
// sar_tick_counter
// Free-running up-counter with a terminal-count compare. Used both as the
// inter-conversion period counter and as the conversion watchdog.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset
//   clr_i    in   synchronous clear (count returns to 0)
//   en_i     in   count enable
//   limit_i  in   terminal count to compare against
//   hit_o    out  high while the count equals limit_i
module sar_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/sar_oversample_ctrl.sv
// sar_oversample_ctrl
// Schedules periodic conversions on the SAR controller, accumulates 2^LogN
// results and publishes their truncated mean. A watchdog aborts any
// conversion that does not return eoc_i within TimeoutCycles cycles.
//
// Ports:
//   clk_i     in   clock (shared with the SAR controller)
//   rst_i     in   synchronous active-high reset
//   en_i      in   scheduling enable
//   period_i  in   idle cycles between conversions, latched on WAIT entry
//   start_o   out  one-cycle start request to the SAR controller
//   eoc_i     in   SAR end-of-conversion strobe
//   result_i  in   SAR result, valid with eoc_i
//   avg_o     out  mean of the last completed batch
//   sum_o     out  raw sum of the last completed batch
//   valid_o   out  one-cycle pulse when avg_o/sum_o update
//   error_o   out  sticky watchdog flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | scheduling off, accumulator and sample count held at 0
// WAIT  | counting period+1 idle cycles before the next start
// START | start_o high for one cycle
// CONV  | waiting for eoc_i, watchdog running
module sar_oversample_ctrl
  import sar_pkg::*;
#(
  parameter int Width         = SAR_WIDTH,
  parameter int LogN          = 2,
  parameter int PeriodW       = 8,
  parameter int TimeoutCycles = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [PeriodW-1:0]    period_i,
  output logic                  start_o,
  input  logic                  eoc_i,
  input  logic [Width-1:0]      result_i,
  output logic [Width-1:0]      avg_o,
  output logic [Width+LogN-1:0] sum_o,
  output logic                  valid_o,
  output logic                  error_o
);

  localparam int AccW = Width + LogN;
  localparam int NsW  = LogN + 1;
  localparam int WdW  = $clog2(TimeoutCycles + 1);
  localparam logic [WdW-1:0] WdLimit  = WdW'(TimeoutCycles - 1);
  localparam logic [NsW-1:0] LastSamp = NsW'((1 << LogN) - 1);

  sar_os_state_t state_q, state_d;

  logic [PeriodW-1:0] period_q;
  logic [AccW-1:0]    acc_q;
  logic [AccW-1:0]    acc_sum;
  logic [NsW-1:0]     nsamp_q;
  logic               per_hit;
  logic               wd_hit;
  logic               accept;
  logic               abort;
  logic               enter_wait;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = WAIT;
      WAIT: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (per_hit) begin
          state_d = START;
        end
      end
      START:   state_d = CONV;
      CONV:    if (eoc_i || wd_hit) state_d = en_i ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start_o    = (state_q == START);
  assign accept     = (state_q == CONV) && eoc_i;
  // eoc_i in the watchdog's final cycle still counts as a good sample.
  assign abort      = (state_q == CONV) && !eoc_i && wd_hit;
  assign enter_wait = (state_d == WAIT) && (state_q != WAIT);
  assign acc_sum    = acc_q + AccW'(result_i);

  // Period counter: cleared outside WAIT so each WAIT starts from 0.
  sar_tick_counter #(.W(PeriodW)) u_period (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (state_q != WAIT),
    .en_i    (state_q == WAIT),
    .limit_i (period_q),
    .hit_o   (per_hit)
  );

  // Watchdog: counts CONV cycles; hit marks the last permitted cycle.
  sar_tick_counter #(.W(WdW)) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (state_q != CONV),
    .en_i    (state_q == CONV),
    .limit_i (WdLimit),
    .hit_o   (wd_hit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_q <= '0;
      acc_q    <= '0;
      nsamp_q  <= '0;
      sum_o    <= '0;
      avg_o    <= '0;
      valid_o  <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (enter_wait) begin
        period_q <= period_i;
      end
      if (accept) begin
        if (nsamp_q == LastSamp) begin
          sum_o   <= acc_sum;
          avg_o   <= acc_sum[AccW-1:LogN];
          valid_o <= 1'b1;
          acc_q   <= '0;
          nsamp_q <= '0;
        end else begin
          acc_q   <= acc_sum;
          nsamp_q <= nsamp_q + NsW'(1);
        end
      end else if (abort) begin
        error_o <= 1'b1;
        acc_q   <= '0;
        nsamp_q <= '0;
      end
      // Leaving for IDLE always drops a partial batch.
      if (state_d == IDLE) begin
        acc_q   <= '0;
        nsamp_q <= '0;
      end
    end
  end

endmodule
